mem_writer: RTL and testbench

Write-side companion to `mem_reader` for the watch's snapshot memory. On each rising edge of `save` it latches the four BCD time digits and writes them as a two-byte record, seconds byte then minutes byte, into an external 8-bit-wide RAM through a registered `we`/`addr`/`wdata` port. `mem_reader` later plays those records back. It sits between `display_handler`, which supplies `save` and the digits, and the shared snapshot RAM.

---
 rtl/watch_pkg.sv | 16 +
 rtl/pos_detect.sv | 19 +
 rtl/mem_writer.sv | 132 +++++++++++++
 tb/tb_mem_writer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/watch_pkg.sv
// Shared watch types and snapshot record layout.
// Byte offsets are common to mem_writer and mem_reader.
package watch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WR_SEC,
    WR_MIN,
    DONE
  } mem_wr_state_t;

  localparam int unsigned REC_BYTES  = 2;
  localparam int unsigned SEC_OFFSET = 0;
  localparam int unsigned MIN_OFFSET = 1;

endpackage

// File: rtl/pos_detect.sv
// Rising-edge detector: one-cycle-wide pulse on 0->1 of sig.
// Rising-edge mirror of neg_detect.
module pos_detect (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic pos_sig
);

  logic r_sig_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sig_q <= 1'b0;
    else     r_sig_q <= sig;
  end

  assign pos_sig = sig & ~r_sig_q;

endmodule

// File: rtl/mem_writer.sv
// Snapshot writer: stores BCD time as {sec, min} byte pairs
// into an external byte-wide RAM via registered we/addr/wdata.
module mem_writer
  import watch_pkg::*;
#(
  parameter int SIZE     = 4,
  parameter int MAX_ADDR = 8,
  parameter int ADDR_W   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                save,
  input  logic                clear,
  input  logic [SIZE-1:0]     seconds_units,
  input  logic [SIZE-1:0]     seconds_tens,
  input  logic [SIZE-1:0]     minutes_units,
  input  logic [SIZE-1:0]     minutes_tens,
  output logic                we,
  output logic [ADDR_W-1:0]   addr,
  output logic [2*SIZE-1:0]   wdata,
  output logic                busy,
  output logic                full,
  output logic [ADDR_W-1:0]   rec_count,
  output logic                overflow
);

  localparam logic [ADDR_W-1:0] LP_LAST =
    ADDR_W'(MAX_ADDR - REC_BYTES);
  localparam logic [ADDR_W-1:0] LP_STEP = ADDR_W'(REC_BYTES);
  localparam logic [ADDR_W-1:0] LP_SEC  = ADDR_W'(SEC_OFFSET);
  localparam logic [ADDR_W-1:0] LP_MIN  = ADDR_W'(MIN_OFFSET);

  mem_wr_state_t r_state, w_state_n;

  logic              w_save_rise;
  logic [ADDR_W-1:0] r_ptr, w_ptr_n;
  logic [ADDR_W-1:0] r_cnt, w_cnt_n;
  logic              r_full, w_full_n;
  logic              r_we, w_we_n;
  logic [ADDR_W-1:0] r_addr, w_addr_n;
  logic [2*SIZE-1:0] r_wdata, w_wdata_n;
  logic [2*SIZE-1:0] r_min, w_min_n;
  logic              r_ovf, w_ovf_n;

  pos_detect u_save_det (
    .clk     (clk),
    .rst     (rst),
    .sig     (save),
    .pos_sig (w_save_rise)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_full  <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_min   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_ptr   <= w_ptr_n;
      r_cnt   <= w_cnt_n;
      r_full  <= w_full_n;
      r_we    <= w_we_n;
      r_addr  <= w_addr_n;
      r_wdata <= w_wdata_n;
      r_min   <= w_min_n;
      r_ovf   <= w_ovf_n;
    end
  end

  // Outputs are registered: each branch sets what the RAM sees next cycle.
  always_comb begin
    w_state_n = r_state;
    w_ptr_n   = r_ptr;
    w_cnt_n   = r_cnt;
    w_full_n  = r_full;
    w_we_n    = 1'b0;
    w_addr_n  = r_addr;
    w_wdata_n = r_wdata;
    w_min_n   = r_min;
    w_ovf_n   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (clear) begin
          w_ptr_n  = '0;
          w_cnt_n  = '0;
          w_full_n = 1'b0;
        end else if (w_save_rise) begin
          if (r_full) begin
            w_ovf_n = 1'b1;
          end else begin
            w_state_n = WR_SEC;
            w_we_n    = 1'b1;
            w_addr_n  = r_ptr + LP_SEC;
            w_wdata_n = {seconds_tens, seconds_units};
            w_min_n   = {minutes_tens, minutes_units};
          end
        end
      end
      WR_SEC: begin
        w_state_n = WR_MIN;
        w_we_n    = 1'b1;
        w_addr_n  = r_ptr + LP_MIN;
        w_wdata_n = r_min;
      end
      WR_MIN: begin
        w_state_n = DONE;
      end
      DONE: begin
        w_state_n = IDLE;
        w_ptr_n   = r_ptr + LP_STEP;
        w_cnt_n   = r_cnt + 1'b1;
        w_full_n  = (r_ptr == LP_LAST);
      end
      default: w_state_n = IDLE;
    endcase
  end

  assign we        = r_we;
  assign addr      = r_addr;
  assign wdata     = r_wdata;
  assign busy      = (r_state != IDLE);
  assign full      = r_full;
  assign rec_count = r_cnt;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_mem_writer.sv
// Self-checking bench for mem_writer: directed table,
// multi-cycle corner sequences and a random record-level model.
module tb_mem_writer;

  localparam int CAP = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       save = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] su = '0, st = '0, mu = '0, mt = '0;
  logic       we;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic       busy;
  logic       full;
  logic [7:0] rec_count;
  logic       overflow;

  int n_tests = 0;
  int n_fail  = 0;

  mem_writer #(.SIZE(4), .MAX_ADDR(8), .ADDR_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .save          (save),
    .clear         (clear),
    .seconds_units (su),
    .seconds_tens  (st),
    .minutes_units (mu),
    .minutes_tens  (mt),
    .we            (we),
    .addr          (addr),
    .wdata         (wdata),
    .busy          (busy),
    .full          (full),
    .rec_count     (rec_count),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         clr;
    logic [3:0] su, st, mu, mt;
    bit         acc;
    logic [7:0] a0;
    logic [7:0] cnt;
    bit         full;
  } vec_t;

  vec_t vecs[6];

  // observations of one save transaction
  int         o_nwe, o_nbusy, o_novf;
  bit         o_ovf1;
  logic [7:0] o_a[2];
  logic [7:0] o_d[2];

  int m_cnt;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_save(input logic [3:0] a, b, c, d,
                          input bit disturb);
    o_nwe = 0; o_nbusy = 0; o_novf = 0; o_ovf1 = 0;
    o_a[0] = 'x; o_a[1] = 'x; o_d[0] = 'x; o_d[1] = 'x;
    @(negedge clk);
    su = a; st = b; mu = c; mt = d;
    save = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (we) begin
        if (o_nwe < 2) begin
          o_a[o_nwe] = addr;
          o_d[o_nwe] = wdata;
        end
        o_nwe++;
      end
      if (busy) o_nbusy++;
      if (overflow) begin
        o_novf++;
        if (i == 1) o_ovf1 = 1;
      end
      if (i == 1) begin
        save = 1'b0;
        su = ~a; st = ~b; mu = ~c; mt = ~d;
        if (disturb) clear = 1'b1;
      end
      if (i == 2 && disturb) save = 1'b1;
      if (i == 3) begin
        save = 1'b0;
        clear = 1'b0;
      end
    end
  endtask

  task automatic check_save(input string tag, input bit acc,
                            input logic [7:0] a0, sec, min,
                            input logic [7:0] cnt, input bit f);
    if (acc) begin
      chk({tag, " nwe"}, o_nwe, 2);
      chk({tag, " addr0"}, o_a[0], a0);
      chk({tag, " addr1"}, o_a[1], a0 + 8'd1);
      chk({tag, " sec"}, o_d[0], sec);
      chk({tag, " min"}, o_d[1], min);
      chk({tag, " busy"}, o_nbusy, 3);
      chk({tag, " ovf"}, o_novf, 0);
    end else begin
      chk({tag, " nwe"}, o_nwe, 0);
      chk({tag, " busy"}, o_nbusy, 0);
      chk({tag, " ovf"}, o_novf, 1);
      chk({tag, " ovf_t"}, o_ovf1, 1);
    end
    chk({tag, " cnt"}, rec_count, cnt);
    chk({tag, " full"}, full, f);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clr cnt", rec_count, 0);
    chk("clr full", full, 0);
    m_cnt = 0;
  endtask

  // model-driven save: record count decides acceptance and address
  task automatic model_save(input string tag, input logic [3:0] a, b, c, d,
                            input bit disturb);
    bit acc;
    logic [7:0] a0;
    acc = (m_cnt < CAP);
    a0 = 8'(2 * m_cnt);
    run_save(a, b, c, d, disturb);
    if (acc) m_cnt++;
    check_save(tag, acc, a0, {b, a}, {d, c}, 8'(m_cnt), m_cnt == CAP);
  endtask

  int nwe;
  logic [7:0] wa[4];

  initial begin
    vecs[0] = '{0, 1, 2, 3, 4, 1, 8'd0, 8'd1, 0};
    vecs[1] = '{0, 5, 0, 9, 5, 1, 8'd2, 8'd2, 0};
    vecs[2] = '{0, 9, 5, 0, 0, 1, 8'd4, 8'd3, 0};
    vecs[3] = '{0, 0, 0, 5, 5, 1, 8'd6, 8'd4, 1};
    vecs[4] = '{0, 7, 1, 2, 3, 0, 8'd0, 8'd4, 1};
    vecs[5] = '{1, 3, 3, 3, 3, 1, 8'd0, 8'd1, 0};

    repeat (2) @(negedge clk);
    chk("rst we", we, 0);
    chk("rst addr", addr, 0);
    chk("rst wdata", wdata, 0);
    chk("rst busy", busy, 0);
    chk("rst full", full, 0);
    chk("rst cnt", rec_count, 0);
    chk("rst ovf", overflow, 0);
    rst = 1'b0;

    foreach (vecs[k]) begin
      if (vecs[k].clr) do_clear();
      run_save(vecs[k].su, vecs[k].st, vecs[k].mu, vecs[k].mt, 0);
      check_save($sformatf("vec%0d", k), vecs[k].acc, vecs[k].a0,
                 {vecs[k].st, vecs[k].su}, {vecs[k].mt, vecs[k].mu},
                 vecs[k].cnt, vecs[k].full);
    end

    // level save held high writes only once per rising edge
    do_clear();
    nwe = 0;
    @(negedge clk);
    save = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (we) begin
        if (nwe < 4) wa[nwe] = addr;
        nwe++;
      end
    end
    save = 1'b0;
    @(negedge clk);
    save = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (we) begin
        if (nwe < 4) wa[nwe] = addr;
        nwe++;
      end
    end
    save = 1'b0;
    chk("hold nwe", nwe, 4);
    chk("hold a0", wa[0], 0);
    chk("hold a1", wa[1], 1);
    chk("hold a2", wa[2], 2);
    chk("hold a3", wa[3], 3);
    chk("hold cnt", rec_count, 2);
    m_cnt = 2;

    // clear and save rise together: clear wins
    @(negedge clk);
    clear = 1'b1;
    save = 1'b1;
    @(negedge clk);
    chk("cs cnt", rec_count, 0);
    chk("cs we", we, 0);
    clear = 1'b0;
    nwe = 0;
    repeat (3) begin
      @(negedge clk);
      if (we) nwe++;
    end
    chk("cs nowr", nwe, 0);
    save = 1'b0;
    m_cnt = 0;
    model_save("cs next", 4'd8, 4'd2, 4'd7, 4'd1, 0);

    // save edge and clear while busy are ignored
    model_save("busy dist", 4'd6, 4'd4, 4'd2, 4'd0, 1);
    @(negedge clk);
    chk("dist nowe", we, 0);
    chk("dist idle", busy, 0);

    // reset during WR_MIN aborts immediately
    @(negedge clk);
    su = 4'd1; st = 4'd1; mu = 4'd1; mt = 4'd1;
    save = 1'b1;
    @(negedge clk);
    save = 1'b0;
    @(negedge clk);
    chk("pre rst we", we, 1);
    rst = 1'b1;
    #1;
    chk("arst we", we, 0);
    chk("arst busy", busy, 0);
    chk("arst cnt", rec_count, 0);
    chk("arst addr", addr, 0);
    @(negedge clk);
    rst = 1'b0;
    m_cnt = 0;
    model_save("post rst", 4'd2, 4'd3, 4'd4, 4'd5, 0);

    // random save/clear mix against the record-level model
    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(0, 4) == 0) do_clear();
      else model_save($sformatf("rnd%0d", r),
                      4'($urandom_range(0, 9)), 4'($urandom_range(0, 5)),
                      4'($urandom_range(0, 9)), 4'($urandom_range(0, 5)),
                      0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
